// File: rtl/if_fetch_pkg.sv
// Shared widths and FSM encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: turns the PC stream into variable-latency memory requests,
// squashes wrong-path words after a branch and buffers a word while IF is held.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   br,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   right_one_i,
  output logic                   mem_req,
  output logic [InstAddrBus-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [InstBus-1:0]     mem_rdata,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   if_valid,
  output logic                   if_right_one,
  output logic                   stallreq_if
);

  if_state_e              state_reg, state_next;
  logic [InstAddrBus-1:0] addr_reg, addr_next;
  logic                   tgt_reg, tgt_next;
  logic                   kill_reg, kill_next;

  logic [InstAddrBus-1:0] out_pc_reg, out_pc_next;
  logic [InstBus-1:0]     out_inst_reg, out_inst_next;
  logic                   out_valid_reg, out_valid_next;
  logic                   out_ro_reg, out_ro_next;

  logic [InstAddrBus-1:0] buf_pc_reg, buf_pc_next;
  logic [InstBus-1:0]     buf_inst_reg, buf_inst_next;
  logic                   buf_valid_reg, buf_valid_next;
  logic                   buf_ro_reg, buf_ro_next;

  logic launch;
  logic deliver_ok;
  logic unused_stall;

  assign unused_stall = ^{stall[5:2], stall[0]};

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    tgt_next       = tgt_reg;
    out_pc_next    = out_pc_reg;
    out_inst_next  = out_inst_reg;
    out_valid_next = out_valid_reg;
    out_ro_next    = out_ro_reg;
    buf_pc_next    = buf_pc_reg;
    buf_inst_next  = buf_inst_reg;
    buf_valid_next = buf_valid_reg;
    buf_ro_next    = buf_ro_reg;
    launch         = 1'b0;
    // A branch in the same cycle as the ack squashes the word as well.
    deliver_ok     = !kill_reg && !br;

    case (state_reg)
      IF_IDLE: begin
        state_next = IF_FETCH;
        launch     = 1'b1;
      end
      IF_FETCH: begin
        if (mem_ack) begin
          if (!stall[1]) begin
            out_valid_next = deliver_ok;
            if (deliver_ok) begin
              out_pc_next   = addr_reg;
              out_inst_next = mem_rdata;
              out_ro_next   = tgt_reg;
            end
            launch = 1'b1;
          end else begin
            buf_valid_next = deliver_ok;
            if (deliver_ok) begin
              buf_pc_next   = addr_reg;
              buf_inst_next = mem_rdata;
              buf_ro_next   = tgt_reg;
            end
            state_next = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        if (!stall[1]) begin
          out_pc_next    = buf_pc_reg;
          out_inst_next  = buf_inst_reg;
          out_valid_next = buf_valid_reg;
          out_ro_next    = buf_ro_reg;
          launch         = 1'b1;
          state_next     = IF_FETCH;
        end
      end
      default: state_next = IF_IDLE;
    endcase

    if (launch) begin
      addr_next = pc_i;
      tgt_next  = right_one_i;
    end

    // br outranks a simultaneous launch of the branch target.
    if (br)
      kill_next = 1'b1;
    else if (launch && right_one_i)
      kill_next = 1'b0;
    else
      kill_next = kill_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IF_IDLE;
      addr_reg      <= '0;
      tgt_reg       <= 1'b0;
      kill_reg      <= 1'b0;
      out_pc_reg    <= '0;
      out_inst_reg  <= ZeroWord;
      out_valid_reg <= 1'b0;
      out_ro_reg    <= 1'b0;
      buf_pc_reg    <= '0;
      buf_inst_reg  <= ZeroWord;
      buf_valid_reg <= 1'b0;
      buf_ro_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      tgt_reg       <= tgt_next;
      kill_reg      <= kill_next;
      out_pc_reg    <= out_pc_next;
      out_inst_reg  <= out_inst_next;
      out_valid_reg <= out_valid_next;
      out_ro_reg    <= out_ro_next;
      buf_pc_reg    <= buf_pc_next;
      buf_inst_reg  <= buf_inst_next;
      buf_valid_reg <= buf_valid_next;
      buf_ro_reg    <= buf_ro_next;
    end
  end

  assign mem_req      = (state_reg == IF_FETCH);
  assign mem_addr     = addr_reg;
  assign stallreq_if  = (state_reg == IF_FETCH && !mem_ack) || (state_reg == IF_IDLE);
  assign if_pc        = out_pc_reg;
  assign if_inst      = out_inst_reg;
  assign if_valid     = out_valid_reg;
  assign if_right_one = out_ro_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle vector table plus hold and reset-mid-wait sequences.
module tb_if_fetch;

  typedef struct {
    logic        rst;
    logic        st1;
    logic        br;
    logic [31:0] pc;
    logic        ro;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_ro;
    logic        e_sreq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        br;
  logic [31:0] pc_i;
  logic        right_one_i;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_right_one;
  logic        stallreq_if;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br           (br),
    .pc_i         (pc_i),
    .right_one_i  (right_one_i),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid),
    .if_right_one (if_right_one),
    .stallreq_if  (stallreq_if)
  );

  function automatic vec_t mk(input logic r, input logic s1, input logic b, input logic [31:0] p,
                              input logic ro, input logic ack, input logic [31:0] rd,
                              input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                              input logic [31:0] e_inst, input logic e_valid, input logic e_ro,
                              input logic e_sreq);
    vec_t v;
    v.rst = r; v.st1 = s1; v.br = b; v.pc = p; v.ro = ro; v.ack = ack; v.rdata = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_valid = e_valid; v.e_ro = e_ro; v.e_sreq = e_sreq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs applied at negedge, outputs checked 1 ns later (before the next rising edge).
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    rst = v.rst; stall = {4'b0, v.st1, 1'b0}; br = v.br; pc_i = v.pc;
    right_one_i = v.ro; mem_ack = v.ack; mem_rdata = v.rdata;
    #1;
    chk({name, ".mem_req"},      {31'b0, mem_req},      {31'b0, v.e_req});
    chk({name, ".mem_addr"},     mem_addr,              v.e_addr);
    chk({name, ".if_pc"},        if_pc,                 v.e_pc);
    chk({name, ".if_inst"},      if_inst,               v.e_inst);
    chk({name, ".if_valid"},     {31'b0, if_valid},     {31'b0, v.e_valid});
    chk({name, ".if_right_one"}, {31'b0, if_right_one}, {31'b0, v.e_ro});
    chk({name, ".stallreq_if"},  {31'b0, stallreq_if},  {31'b0, v.e_sreq});
    $display("step %-6s rst=%0b st1=%0b br=%0b pc_i=%08h ro=%0b ack=%0b | req=%0b addr=%08h if_pc=%08h inst=%08h v=%0b ro=%0b sreq=%0b",
             name, v.rst, v.st1, v.br, v.pc, v.ro, v.ack, mem_req, mem_addr, if_pc, if_inst,
             if_valid, if_right_one, stallreq_if);
  endtask

  vec_t tbl[$];

  initial begin
    //              rst s1 br pc        ro ack rdata       req addr      if_pc     if_inst   v  ro sreq
    tbl.push_back(mk(0, 0, 0, 32'h004, 0, 0, 32'h0,      0, 32'h000, 32'h000, 32'h00, 0, 0, 1)); // reset
    tbl.push_back(mk(1, 0, 0, 32'h004, 0, 0, 32'h0,      0, 32'h000, 32'h000, 32'h00, 0, 0, 1)); // idle
    tbl.push_back(mk(1, 0, 0, 32'h008, 0, 1, 32'hA1,     1, 32'h004, 32'h000, 32'h00, 0, 0, 0)); // zero-wait
    tbl.push_back(mk(1, 0, 0, 32'h00C, 0, 1, 32'hB2,     1, 32'h008, 32'h004, 32'hA1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h010, 0, 1, 32'hC3,     1, 32'h00C, 32'h008, 32'hB2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h014, 0, 0, 32'h0,      1, 32'h010, 32'h00C, 32'hC3, 1, 0, 1)); // 3-cycle
    tbl.push_back(mk(1, 0, 0, 32'h014, 0, 0, 32'h0,      1, 32'h010, 32'h00C, 32'hC3, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h014, 0, 1, 32'hD4,     1, 32'h010, 32'h00C, 32'hC3, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h018, 0, 0, 32'h0,      1, 32'h014, 32'h010, 32'hD4, 1, 0, 1)); // br in wait
    tbl.push_back(mk(1, 0, 0, 32'h018, 0, 1, 32'hE5,     1, 32'h014, 32'h010, 32'hD4, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h100, 1, 1, 32'hF6,     1, 32'h018, 32'h010, 32'hD4, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h104, 0, 1, 32'h77,     1, 32'h100, 32'h010, 32'hD4, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h108, 0, 0, 32'h0,      1, 32'h104, 32'h100, 32'h77, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 32'h200, 1, 1, 32'h88,     1, 32'h104, 32'h100, 32'h77, 1, 1, 0)); // br+target
    tbl.push_back(mk(1, 0, 0, 32'h204, 0, 1, 32'h99,     1, 32'h200, 32'h100, 32'h77, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h300, 1, 1, 32'hAA,     1, 32'h204, 32'h100, 32'h77, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h304, 0, 1, 32'hBB,     1, 32'h300, 32'h100, 32'h77, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h304, 0, 0, 32'h0,      1, 32'h304, 32'h300, 32'hBB, 1, 1, 1));

    rst = 1'b0; stall = '0; br = 1'b0; pc_i = '0; right_one_i = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("v%0d", i), tbl[i]);

    // IF hold: ack arrives while stall[1] is high, word buffered until release.
    step("hold1", mk(1, 1, 0, 32'h308, 0, 1, 32'hCC, 1, 32'h304, 32'h300, 32'hBB, 1, 1, 0));
    step("hold2", mk(1, 1, 0, 32'h308, 0, 0, 32'h0,  0, 32'h304, 32'h300, 32'hBB, 1, 1, 0));
    step("hold3", mk(1, 0, 0, 32'h308, 0, 0, 32'h0,  0, 32'h304, 32'h300, 32'hBB, 1, 1, 0));
    step("hold4", mk(1, 0, 0, 32'h30C, 0, 0, 32'h0,  1, 32'h308, 32'h304, 32'hCC, 1, 0, 1));

    // Reset during an outstanding fetch, then a stray ack while IDLE.
    step("rmid1", mk(0, 0, 0, 32'h30C, 0, 0, 32'h0,  1, 32'h308, 32'h304, 32'hCC, 1, 0, 1));
    step("rmid2", mk(1, 0, 0, 32'h040, 0, 1, 32'hDD, 0, 32'h000, 32'h000, 32'h00, 0, 0, 1));
    step("rmid3", mk(1, 0, 0, 32'h044, 0, 1, 32'hEE, 1, 32'h040, 32'h000, 32'h00, 0, 0, 0));
    step("rmid4", mk(1, 0, 0, 32'h048, 0, 0, 32'h0,  1, 32'h044, 32'h040, 32'hEE, 1, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
